iobus_arbiter: RTL
==================

# iobus_arbiter

Two-master arbiter that shares the single `iobus` port (RAM, LED, UART registers) between the CPU data port (master 0) and a UART program-loader/DMA engine (master 1). It sits between both masters and `iobus`, muxes one master's command onto the bus per cycle, and returns registered read data to the granted master. Arbitration is round-robin with optional bus locking for multi-transfer sequences such as UART status-poll-then-write.

## Interface
- `MAX_HOLD`, 16: maximum consecutive locked transfers before forced release if the other master is requesting; valid range 1–255.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `m0_req`, `m1_req`  in  1  transfer request, held until `mX_gnt`
- `m0_lock`, `m1_lock`  in  1  keep ownership after this transfer
- `m0_we`, `m1_we`  in  2  00 read, 01 byte, 10 half, 11 word write
- `m0_addr`, `m1_addr`  in  32  byte address
- `m0_wd`, `m1_wd`  in  32  write data
- `m0_gnt`, `m1_gnt`  out  1  transfer executed on bus this cycle
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid, one cycle after `gnt`
- `m0_rdata`, `m1_rdata`  out  32  registered read data
- `bus_we`  out  2  to `iobus` `we`
- `bus_addr`  out  32  to `iobus` `addr`
- `bus_wd`  out  32  to `iobus` `wd`
- `bus_rdata`  in  32  from `iobus` `data` (combinational)

## Operation
- States: IDLE, OWN0, OWN1. Registers: `state`, `last` (last owner, 1 bit), `hold_cnt` (8 bit), `rdata`, `rvalid`, `rsel`.
- IDLE: no grant. If any `req`, go to OWNw. Winner w is the sole requester; on a tie, w = !`last`.
- OWNm: `mm_gnt = mm_req`. Bus carries master m's `we`/`addr`/`wd` when granted, else `bus_we`=00, `bus_addr`=0, `bus_wd`=0.
- Next state from OWNm:
  - `!mm_req`: go to OWN(other) if other requesting, else IDLE.
  - granted, `mm_lock`, and `hold_cnt < MAX_HOLD-1`: stay in OWNm, `hold_cnt++`.
  - granted otherwise: go to OWN(other) if other requesting, else stay in OWNm (parked).
- `hold_cnt` clears on every ownership change and in IDLE. `last` updates to m on every granted transfer.
- Read: on a granted cycle with `we`=00, `rdata <= bus_rdata`, `rvalid <= 1`, `rsel <= m`. `mX_rvalid = rvalid && rsel==X`. Both `mX_rdata` outputs present `rdata`.
- Writes produce no `rvalid`. The arbiter does not decode addresses; all regions behave identically.
- A UART write to address 0xFFF1_0004 is a single granted cycle. Sequencing byte-per-busy is the master's job, done via lock.

## Timing
- Reset values: state IDLE, `last`=1 (so m0 wins the first tie), `hold_cnt`=0, `rvalid`=0, `rdata`=0, all `gnt`=0, `bus_we`=00, `bus_addr`=0, `bus_wd`=0.
- Latency from IDLE: `req` in cycle N produces `gnt` in cycle N+1. A parked owner gets `gnt` in the same cycle as `req`.
- Throughput: 1 transfer/cycle with a single requester. With both requesting and unlocked, grants alternate every cycle.
- `gnt` and `bus_*` are combinational from `state` and the owner's inputs. No path exists from the other master's inputs to the bus.
- Read data is valid exactly one cycle after `gnt`, for one cycle.
- Reset mid-transfer clears all outputs asynchronously. A write on that edge is not guaranteed.
- Locked owner with `MAX_HOLD`=1 behaves as unlocked.

## Configuration
- `IOBUS_ARB_LOCK_EN` defined: lock behaviour as above.
- Not defined: `mX_lock` inputs are ignored, `hold_cnt` is removed, and every granted transfer re-arbitrates.

## Structure
- `iobus_pkg`:
  - `arb_state_t` enum (IDLE, OWN0, OWN1)
  - `bus_we_t` constants (`WE_RD`, `WE_B`, `WE_H`, `WE_W`)
  - region bases `LED_BASE`=16'hFFF0, `UART_BASE`=16'hFFF1
- Single module, no sub-module: the next-state logic and bus mux are small enough to live in one file.

## Test plan
- Reset release, then m0 writes byte 0xAB to 0x10 → `m0_gnt` one cycle after `req`, `bus_we`=01, `bus_addr`=0x10, `bus_wd`=0xAB; `m1_gnt`=0 throughout.
- Both masters request continuously, unlocked → grant order m0, m1, m0, m1 with no idle cycle.
- `IOBUS_ARB_LOCK_EN`, `MAX_HOLD`=4, m1 locked, m0 requesting → four consecutive `m1_gnt`, then `m0_gnt`.
- m0 reads 0xFFF1_0008 with `bus_rdata`=0x3 → next cycle `m0_rvalid`=1, `m0_rdata`=0x3, `m1_rvalid`=0.
- `reset` pulled low during OWN1 with m1 writing → `m1_gnt`=0 and `bus_we`=00 immediately; after release, state is IDLE and m0 wins the tie.
- Macro undefined, both masters locked and requesting → strict alternation m0, m1, m0.

Source files
------------

// File: rtl/iobus_pkg.sv
// Shared types and constants for the iobus two-master arbiter slice.
package iobus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic [1:0] bus_we_t;

  localparam bus_we_t WE_RD = 2'b00;
  localparam bus_we_t WE_B  = 2'b01;
  localparam bus_we_t WE_H  = 2'b10;
  localparam bus_we_t WE_W  = 2'b11;

  localparam logic [15:0] LED_BASE  = 16'hFFF0;
  localparam logic [15:0] UART_BASE = 16'hFFF1;

endpackage

// File: rtl/iobus_arbiter.sv
// Round-robin arbiter sharing iobus between the CPU data port and the UART loader.
// Define IOBUS_ARB_LOCK_EN to honour mX_lock with a MAX_HOLD transfer limit.
module iobus_arbiter
  import iobus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [1:0]  m0_we,
  input  logic [1:0]  m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wd,
  input  logic [31:0] m1_wd,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [1:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wd,
  input  logic [31:0] bus_rdata
);

  arb_state_t  state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        rsel_q, rsel_d;
  logic        keep0, keep1;

`ifdef IOBUS_ARB_LOCK_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;

  assign keep0 = m0_lock && (hold_cnt_q < HOLD_LIM);
  assign keep1 = m1_lock && (hold_cnt_q < HOLD_LIM);
`else
  logic unused_lock;

  assign keep0       = 1'b0;
  assign keep1       = 1'b0;
  assign unused_lock = m0_lock ^ m1_lock ^ (MAX_HOLD == 0);
`endif

  // Grant and bus mux only look at the current owner's inputs.
  always_comb begin
    m0_gnt   = (state_q == OWN0) && m0_req;
    m1_gnt   = (state_q == OWN1) && m1_req;
    bus_we   = WE_RD;
    bus_addr = '0;
    bus_wd   = '0;
    if (m0_gnt) begin
      bus_we   = m0_we;
      bus_addr = m0_addr;
      bus_wd   = m0_wd;
    end else if (m1_gnt) begin
      bus_we   = m1_we;
      bus_addr = m1_addr;
      bus_wd   = m1_wd;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = last_q ? OWN0 : OWN1;
        else if (m0_req)      state_d = OWN0;
        else if (m1_req)      state_d = OWN1;
      end
      OWN0: begin
        if (!m0_req) begin
          state_d = m1_req ? OWN1 : IDLE;
        end else begin
          last_d = 1'b0;
          if (!keep0 && m1_req) state_d = OWN1;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          state_d = m0_req ? OWN0 : IDLE;
        end else begin
          last_d = 1'b1;
          if (!keep1 && m0_req) state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase

    rvalid_d = (m0_gnt || m1_gnt) && (bus_we == WE_RD);
    rdata_d  = rvalid_d ? bus_rdata : rdata_q;
    rsel_d   = rvalid_d ? m1_gnt : rsel_q;
  end

`ifdef IOBUS_ARB_LOCK_EN
  // Ownership change or IDLE clears the count; a locked stay extends it.
  always_comb begin
    if ((state_d != state_q) || (state_q == IDLE))
      hold_cnt_d = '0;
    else if ((m0_gnt && keep0) || (m1_gnt && keep1))
      hold_cnt_d = hold_cnt_q + 8'd1;
    else
      hold_cnt_d = hold_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rsel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rsel_q   <= rsel_d;
    end
  end

  assign m0_rvalid = rvalid_q && !rsel_q;
  assign m1_rvalid = rvalid_q && rsel_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

endmodule
